// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: who last owned the
// port, and whether a DMA burst currently holds it.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; under contention
// the requester that did not own the port last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // last=1 means requester 1 owned the port most recently.
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core load/store path and a DMA/debug loader onto one
// single-cycle data memory port, with a bounded DMA burst lock.
//
// state     | meaning
// ST_IDLE   | round-robin between core and DMA, based on last owner
// ST_LOCKED | DMA burst owns the port; core served only when dma_req=0
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [DATA_W-1:0]      core_wdata,
  output logic                   core_gnt,
  output logic                   core_stall,
  output logic [DATA_W-1:0]      core_rdata,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic                   dma_lock,
  input  logic [ADDR_W-1:0]      dma_addr,
  input  logic [DATA_W-1:0]      dma_wdata,
  output logic                   dma_gnt,
  output logic [DATA_W-1:0]      dma_rdata,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  state_e              state_q, state_d;
  owner_e              last_q, last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                rr_core, rr_dma;
  logic                burst_done;

  rr_pick2 u_rr (
    .req0 (core_req),
    .req1 (dma_req),
    .last (last_q == OWN_DMA),
    .gnt0 (rr_core),
    .gnt1 (rr_dma)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= OWN_DMA;
      beat_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      if (core_stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // The core has waited a full burst; this beat is the last one DMA keeps.
  assign burst_done = core_req && (beat_q >= BEAT_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    if (core_gnt) begin
      last_d = OWN_CORE;
    end else if (dma_gnt) begin
      last_d = OWN_DMA;
    end
    unique case (state_q)
      ST_IDLE: begin
        // A one-beat budget is already spent by the entering beat if the core waits.
        if (dma_gnt && dma_lock && !(core_req && (MAX_BURST == 1))) begin
          state_d = ST_LOCKED;
          beat_d  = BEAT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!dma_req || !dma_lock || burst_done) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else if (beat_q < BEAT_LAST) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        dma_gnt  = dma_req;
        core_gnt = core_req & ~dma_req;
      end else begin
        core_gnt = rr_core;
        dma_gnt  = rr_dma;
      end
    end
  end

  assign core_stall = core_req & ~core_gnt & ~rst;
  assign mem_we     = (core_gnt & core_we) | (dma_gnt & dma_we);
  assign mem_addr   = dma_gnt ? dma_addr  : core_addr;
  assign mem_wdata  = dma_gnt ? dma_wdata : core_wdata;
  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-cycle core's data memory port between the core's load/store path and a DMA/debug loader. Same-cycle grant: the core keeps single-cycle timing when uncontended and stalls only on conflict. Supports round-robin under contention and a bounded DMA burst lock. Sits between the core's ALU result / rs2 / MemRW signals and the D_MEM instance.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive locked DMA beats before a forced core slot (≥1)
- STALL_CNT_W, 16, width of the saturating core-stall counter

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core requests an access this cycle
- core_we  in  1  core access is a write
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access performed this cycle
- core_stall  out  1  core_req & ~core_gnt; core must hold PC and request
- core_rdata  out  DATA_W  read data (mem_rdata broadcast)
- dma_req  in  1  DMA requests an access
- dma_we  in  1  DMA access is a write
- dma_lock  in  1  DMA wants ownership to persist after this beat
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  DATA_W  read data (mem_rdata broadcast)
- mem_we  out  1  write strobe to data memory (MemRW)
- mem_addr  out  ADDR_W  muxed address
- mem_wdata  out  DATA_W  muxed write data
- mem_rdata  in  DATA_W  combinational read data from memory
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with core_stall=1

## Operation
- Registered state: owner FSM {IDLE, LOCKED}, last_owner (CORE/DMA), beat_cnt, stall_cnt.
- IDLE grant: only one requester → that one; both → the one ≠ last_owner. Grant updates last_owner at the clock edge.
- IDLE→LOCKED: dma_gnt & dma_lock. LOCKED: DMA has absolute priority whenever dma_req=1; core is granted only in a cycle with dma_req=0.
- beat_cnt counts locked DMA grants, including the entering beat. beat_cnt==MAX_BURST-1 on a DMA grant while core_req=1 → next state IDLE with last_owner=DMA (core wins next contention). With core_req=0 the lock continues and beat_cnt saturates.
- LOCKED→IDLE also whenever dma_lock=0 on a cycle with dma_req=1, or dma_req=0 for a cycle. beat_cnt clears on entry to IDLE.
- Datapath: mem_addr/mem_wdata come from the granted requester; default core when no grant. mem_we = (core_gnt&core_we)|(dma_gnt&dma_we). Exactly one of core_gnt/dma_gnt is high, or neither.
- stall_cnt increments every cycle core_stall=1 and saturates at all-ones.

## Timing
- Grants and mem_* are combinational from the request inputs plus registered state: zero-cycle latency. Write commits at the edge ending the grant cycle. Read data is valid in the grant cycle.
- Requester holds req/addr/wdata/we stable until it is granted. A dropped request is simply not serviced.
- Reset (rst=1): owner=IDLE, last_owner=DMA, beat_cnt=0, stall_cnt=0. While rst=1, core_gnt=dma_gnt=mem_we=0 and core_stall=0. Reset mid-burst aborts the lock with no write performed that cycle.
- Simultaneous lock request and core request in IDLE: normal round-robin applies. The lock is taken only if DMA wins.

## Structure
- Shared package: owner encoding (OWN_CORE, OWN_DMA) and FSM state encoding (ST_IDLE, ST_LOCKED).
- One natural sub-module: rr_pick2, the 2-way round-robin pick from (req0, req1, last). Counters and muxes are inline.

## Test plan
- Core-only: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF for 1 cycle → core_gnt=1, core_stall=0, mem_we=1; subsequent read of 0x10 returns 0xDEADBEEF.
- Contention after reset: both req in cycle 0 → core granted cycle 0, DMA cycle 1; both held in cycle 2 → core granted (alternation); stall_cnt=1 after cycle 1.
- Lock with MAX_BURST=8: DMA wins with dma_lock=1, core_req held high → 8 consecutive dma_gnt, core granted on cycle 9, stall_cnt=8.
- Lock without core traffic: 20 locked DMA beats with core_req=0 → all 20 granted, state stays LOCKED. dma_lock=0 on beat 21 → IDLE afterwards.
- Reset mid-burst: rst=1 at beat 3 of a locked write burst → mem_we=0 that cycle, all grants 0. After release, core alone requesting → core_gnt=1 immediately, stall_cnt=0.
- Saturation with STALL_CNT_W=4: core starved for 20 cycles by locked DMA and alternation → stall_cnt stops at 15.
